// File: rtl/pulse_stretcher_if.sv
// Event-strobe / stretched-pulse bundle for pulse_stretcher.
// The master drives strobes; the slave (the stretcher) drives the pulse and status.
interface pulse_stretcher_if #(
  parameter int PEND_W = 3
);
  logic              in_pulse;
  logic              out;
  logic              busy;
  logic              done;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output in_pulse,
    input  out, busy, done, pending, overflow
  );

  modport slave (
    input  in_pulse,
    output out, busy, done, pending, overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Turns single-cycle strobes into HIGH_LEN-wide pulses separated by GAP_LEN low cycles.
// Define PULSE_RETRIGGER_EN to let strobes during a pulse extend it instead of queueing.
module pulse_stretcher #(
  parameter int HIGH_LEN = 4,
  parameter int GAP_LEN  = 2,
  parameter int CNT_W    = 8,
  parameter int PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  pulse_stretcher_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              queue_evt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    queue_evt = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_pulse) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end

      HIGH: begin
`ifdef PULSE_RETRIGGER_EN
        // A strobe mid-pulse restarts the high phase rather than queueing.
        if (bus.in_pulse) begin
          cnt_d = HIGH_LOAD;
        end else if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        queue_evt = bus.in_pulse;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end

      GAP: begin
        if (cnt_q == '0) begin
          // At the gap exit a live strobe and a dequeue cancel out.
          if ((pend_q != '0) || bus.in_pulse) begin
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
            if ((pend_q != '0) && !bus.in_pulse) begin
              pend_d = pend_q - PEND_ONE;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d     = cnt_q - 1'b1;
          queue_evt = bus.in_pulse;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (queue_evt) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end

    out_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scoreboard bench for pulse_stretcher with HIGH_LEN=4, GAP_LEN=2, PEND_W=2.
// Each step queues its hand-derived expected outputs, clocks once, then pops and checks.
module tb_pulse_stretcher;

  typedef struct packed {
    logic       out;
    logic       busy;
    logic       done;
    logic       ovf;
    logic [1:0] pend;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   stepNo;
  exp_t expq[$];

  pulse_stretcher_if #(.PEND_W(2)) bus ();

  pulse_stretcher #(
    .HIGH_LEN (4),
    .GAP_LEN  (2),
    .CNT_W    (8),
    .PEND_W   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(input logic o, input logic b, input logic d,
                              input logic v, input logic [1:0] p);
    exp_t e;
    e.out  = o;
    e.busy = b;
    e.done = d;
    e.ovf  = v;
    e.pend = p;
    return e;
  endfunction

  task automatic checkOutput();
    exp_t e;
    vectors++;
    assert (expq.size() > 0) else begin
      miscompares++;
      $error("[TB] FAIL step%0d scoreboard empty: observed size %0d, expected > 0", stepNo, expq.size());
    end
    if (expq.size() > 0) begin
      e = expq.pop_front();
      vectors++;
      assert (bus.out === e.out) else begin
        miscompares++;
        $error("[TB] FAIL step%0d out: observed %b, expected %b", stepNo, bus.out, e.out);
      end
      vectors++;
      assert (bus.busy === e.busy) else begin
        miscompares++;
        $error("[TB] FAIL step%0d busy: observed %b, expected %b", stepNo, bus.busy, e.busy);
      end
      vectors++;
      assert (bus.done === e.done) else begin
        miscompares++;
        $error("[TB] FAIL step%0d done: observed %b, expected %b", stepNo, bus.done, e.done);
      end
      vectors++;
      assert (bus.overflow === e.ovf) else begin
        miscompares++;
        $error("[TB] FAIL step%0d overflow: observed %b, expected %b", stepNo, bus.overflow, e.ovf);
      end
      vectors++;
      assert (bus.pending === e.pend) else begin
        miscompares++;
        $error("[TB] FAIL step%0d pending: observed %0d, expected %0d", stepNo, bus.pending, e.pend);
      end
    end
  endtask

  // One clock: drive inputs, queue the expectation for this edge, check just after it.
  task automatic applyStimulus(input logic r, input logic ip, input exp_t e);
    stepNo++;
    expq.push_back(e);
    rst          = r;
    bus.in_pulse = ip;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic resetAndSettle();
    applyStimulus(1'b0, 1'b0, ex(0, 0, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    stepNo       = 0;
    rst          = 1'b0;
    bus.in_pulse = 1'b0;
    #1;

    $display("[TB] reset overrides strobes");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, ex(0, 0, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));

    $display("[TB] single strobe");
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 1, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));

    $display("[TB] strobe at gap exit");
    resetAndSettle();
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 1, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 1, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));

`ifdef PULSE_RETRIGGER_EN
    $display("[TB] retrigger extends pulse");
    resetAndSettle();
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 1, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));
`else
    $display("[TB] two strobes queue one pulse");
    resetAndSettle();
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd1));
    applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd1));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 1, 0, 2'd1));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 0, 0, 2'd1));
    applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 1, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));

    $display("[TB] saturation and overflow");
    resetAndSettle();
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd1));
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd2));
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd3));
    applyStimulus(1'b1, 1'b1, ex(0, 1, 1, 1, 2'd3));
    applyStimulus(1'b1, 1'b1, ex(0, 1, 0, 1, 2'd3));
    for (int p = 2; p >= 0; p--) begin
      applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'(p)));
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, ex(1, 1, 0, 0, 2'(p)));
      applyStimulus(1'b1, 1'b0, ex(0, 1, 1, 0, 2'(p)));
      applyStimulus(1'b1, 1'b0, ex(0, 1, 0, 0, 2'(p)));
    end
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));

    $display("[TB] reset mid-pulse discards queue");
    resetAndSettle();
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd1));
    applyStimulus(1'b1, 1'b1, ex(1, 1, 0, 0, 2'd2));
    applyStimulus(1'b0, 1'b1, ex(0, 0, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));
    applyStimulus(1'b1, 1'b0, ex(0, 0, 0, 0, 2'd0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
